// File: rtl/regbank_dbg_arbiter_pkg.sv
// Shared constants and FSM state type for the register-bank debug arbiter.
// The WR_* states exist only when REGBANK_DBG_WRITE_EN is defined.
package regbank_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int LAST_REG   = NUM_REGS - 1;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_DRAIN   = 3'd1;
  localparam logic [2:0] ST_RD_ADDR = 3'd2;
  localparam logic [2:0] ST_RD_DATA = 3'd3;
  localparam logic [2:0] ST_WR_ADDR = 3'd4;
  localparam logic [2:0] ST_WR_DATA = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_DRAIN   = ST_DRAIN,
    S_RD_ADDR = ST_RD_ADDR,
    S_RD_DATA = ST_RD_DATA
`ifdef REGBANK_DBG_WRITE_EN
    ,
    S_WR_ADDR = ST_WR_ADDR,
    S_WR_DATA = ST_WR_DATA
`endif
  } state_t;

endpackage

// File: rtl/regbank_dbg_arbiter_if.sv
// Bundle of pipeline, register-bank and debug-unit signals around the arbiter.
// slave = arbiter side, master = surrounding pipeline / bank / UART debug unit.
interface regbank_dbg_arbiter_if #(parameter int DATA_WIDTH = 32);
  import regbank_pkg::*;

  logic                  i_wb_regwrite;
  logic [REG_ADDR_W-1:0] i_wb_rd;
  logic [DATA_WIDTH-1:0] i_wb_data;
  logic [REG_ADDR_W-1:0] i_id_rs;
  logic [REG_ADDR_W-1:0] i_id_rt;
  logic                  o_stall;

  logic                  o_rb_regwrite;
  logic [DATA_WIDTH-1:0] o_rb_writedata;
  logic [REG_ADDR_W-1:0] o_rb_rs;
  logic [REG_ADDR_W-1:0] o_rb_rt;
  logic [REG_ADDR_W-1:0] o_rb_rd;
  logic [DATA_WIDTH-1:0] i_rb_regA;

  logic                  i_dbg_dump_req;
  logic                  i_dbg_wr_req;
  logic [REG_ADDR_W-1:0] i_dbg_wr_addr;
  logic [DATA_WIDTH-1:0] i_dbg_wr_data;
  logic                  o_dbg_busy;
  logic                  o_dbg_valid;
  logic                  i_dbg_ready;
  logic [DATA_WIDTH-1:0] o_dbg_data;
  logic                  o_dbg_last;

  modport slave (
    input  i_wb_regwrite, i_wb_rd, i_wb_data, i_id_rs, i_id_rt,
    output o_stall,
    output o_rb_regwrite, o_rb_writedata, o_rb_rs, o_rb_rt, o_rb_rd,
    input  i_rb_regA,
    input  i_dbg_dump_req, i_dbg_wr_req, i_dbg_wr_addr, i_dbg_wr_data, i_dbg_ready,
    output o_dbg_busy, o_dbg_valid, o_dbg_data, o_dbg_last
  );

  modport master (
    output i_wb_regwrite, i_wb_rd, i_wb_data, i_id_rs, i_id_rt,
    input  o_stall,
    input  o_rb_regwrite, o_rb_writedata, o_rb_rs, o_rb_rt, o_rb_rd,
    output i_rb_regA,
    output i_dbg_dump_req, i_dbg_wr_req, i_dbg_wr_addr, i_dbg_wr_data, i_dbg_ready,
    input  o_dbg_busy, o_dbg_valid, o_dbg_data, o_dbg_last
  );

endinterface

// File: rtl/regbank_dbg_arbiter_dbg_word_buffer.sv
// One-entry holding register for dump words: the first presented cycle shows the bank
// output directly, and the word is frozen while the consumer is not ready.
module dbg_word_buffer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  present,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  input  logic                  ready,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  last,
  output logic                  xfer
);

  logic                  held_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  last_q;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      held_q <= 1'b0;
      data_q <= '0;
      last_q <= 1'b0;
    end else if (present && !ready && !held_q) begin
      held_q <= 1'b1;
      data_q <= load_data;
      last_q <= load_last;
    end else if (!present || ready) begin
      held_q <= 1'b0;
    end
  end

  // Outputs are zero whenever no word is presented, so a reset never leaves a stale word.
  assign valid = present;
  assign xfer  = present && ready;
  assign data  = !present ? '0   : (held_q ? data_q : load_data);
  assign last  = !present ? 1'b0 : (held_q ? last_q : load_last);

endmodule

// File: rtl/regbank_dbg_arbiter.sv
// Shares the register bank between the pipeline and the debug unit (dump, optional write).
// Debug write path is built only when REGBANK_DBG_WRITE_EN is defined.
module regbank_dbg_arbiter
  import regbank_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  regbank_dbg_arbiter_if.slave  bus
);

  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_t                state_q, state_d;
  logic [REG_ADDR_W-1:0] index_q, index_d;
  logic [DRAIN_W-1:0]    drain_q, drain_d;
  logic                  present;
  logic                  xfer;
  logic                  buf_valid;
  logic                  buf_last;
  logic [DATA_WIDTH-1:0] buf_data;

`ifdef REGBANK_DBG_WRITE_EN
  logic                  dump_op_q;
  logic [REG_ADDR_W-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;

  // A simultaneous dump request wins; the latched write operands are then simply unused.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      dump_op_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else if (state_q == S_IDLE && (bus.i_dbg_dump_req || bus.i_dbg_wr_req)) begin
      dump_op_q <= bus.i_dbg_dump_req;
      wr_addr_q <= bus.i_dbg_wr_addr;
      wr_data_q <= bus.i_dbg_wr_data;
    end
  end
`else
  logic unused_wr;
  assign unused_wr = ^{bus.i_dbg_wr_req, bus.i_dbg_wr_addr, bus.i_dbg_wr_data};
`endif

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      index_q <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      drain_q <= drain_d;
    end
  end

  // Bank ports default to the pipeline; debug states override only what they own.
  always_comb begin
    state_d            = state_q;
    index_d            = index_q;
    drain_d            = drain_q;
    present            = 1'b0;
    bus.o_stall        = 1'b1;
    bus.o_rb_regwrite  = bus.i_wb_regwrite;
    bus.o_rb_writedata = bus.i_wb_data;
    bus.o_rb_rs        = bus.i_id_rs;
    bus.o_rb_rt        = bus.i_id_rt;
    bus.o_rb_rd        = bus.i_wb_rd;

    case (state_q)
      S_IDLE: begin
        bus.o_stall = 1'b0;
        drain_d     = '0;
        if (bus.i_dbg_dump_req) begin
          state_d = S_DRAIN;
`ifdef REGBANK_DBG_WRITE_EN
        end else if (bus.i_dbg_wr_req) begin
          state_d = S_DRAIN;
`endif
        end
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_W'(DRAIN_CYCLES - 1)) begin
          drain_d = '0;
`ifdef REGBANK_DBG_WRITE_EN
          state_d = dump_op_q ? S_RD_ADDR : S_WR_ADDR;
`else
          state_d = S_RD_ADDR;
`endif
        end else begin
          drain_d = drain_q + DRAIN_W'(1);
        end
      end
      S_RD_ADDR: begin
        bus.o_rb_rs       = index_q;
        bus.o_rb_regwrite = 1'b0;
        state_d           = S_RD_DATA;
      end
      S_RD_DATA: begin
        bus.o_rb_rs       = index_q;
        bus.o_rb_regwrite = 1'b0;
        present           = 1'b1;
        if (xfer) begin
          if (index_q == REG_ADDR_W'(LAST_REG)) begin
            index_d = '0;
            state_d = S_IDLE;
          end else begin
            index_d = index_q + REG_ADDR_W'(1);
            state_d = S_RD_ADDR;
          end
        end
      end
`ifdef REGBANK_DBG_WRITE_EN
      S_WR_ADDR: begin
        bus.o_rb_rd       = wr_addr_q;
        bus.o_rb_regwrite = 1'b0;
        state_d           = S_WR_DATA;
      end
      S_WR_DATA: begin
        bus.o_rb_rd        = wr_addr_q;
        bus.o_rb_regwrite  = 1'b1;
        bus.o_rb_writedata = wr_data_q;
        state_d            = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  dbg_word_buffer #(.DATA_WIDTH(DATA_WIDTH)) u_word_buffer (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .present   (present),
    .load_data (bus.i_rb_regA),
    .load_last (index_q == REG_ADDR_W'(LAST_REG)),
    .ready     (bus.i_dbg_ready),
    .valid     (buf_valid),
    .data      (buf_data),
    .last      (buf_last),
    .xfer      (xfer)
  );

  assign bus.o_dbg_busy  = (state_q != S_IDLE);
  assign bus.o_dbg_valid = buf_valid;
  assign bus.o_dbg_data  = buf_data;
  assign bus.o_dbg_last  = buf_last;

endmodule

// File: tb/tb_regbank_dbg_arbiter.sv
// Bench for regbank_dbg_arbiter: behavioural bank, expected register contents and dump scenarios.
// Write-path scenarios follow REGBANK_DBG_WRITE_EN.
module tb_regbank_dbg_arbiter;
  import regbank_pkg::*;

  logic        clk;
  logic        rst;
  int          total;
  int          bad;

  logic [31:0] bank [32];
  logic [4:0]  bank_rs_q;
  logic [4:0]  bank_rd_q;
  logic [31:0] model [32];

  logic [31:0] got_data [$];
  logic        got_last [$];
  int          unstable_cnt;
  int          cycles_used;
  bit          timed_out;
  logic        busy_first, stall_first, stall_after, valid_after, busy_after;

  regbank_dbg_arbiter_if #(.DATA_WIDTH(32)) bus ();

  regbank_dbg_arbiter #(.DATA_WIDTH(32), .DRAIN_CYCLES(4)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register bank as seen by the arbiter: registered addresses, write one cycle after rd.
  always @(posedge clk) begin
    bank_rs_q <= bus.o_rb_rs;
    bank_rd_q <= bus.o_rb_rd;
    if (bus.o_rb_regwrite) bank[bank_rd_q] <= bus.o_rb_writedata;
  end
  assign bus.i_rb_regA = bank[bank_rs_q];

  task automatic pipe_write(input logic [4:0] r, input logic [31:0] d);
    @(negedge clk);
    bus.i_wb_rd       = r;
    bus.i_wb_regwrite = 1'b0;
    @(negedge clk);
    bus.i_wb_rd       = 5'd0;
    bus.i_wb_regwrite = 1'b1;
    bus.i_wb_data     = d;
    @(negedge clk);
    bus.i_wb_regwrite = 1'b0;
    model[r] = d;
  endtask

  // Call right after raising a request; records transferred words and handshake observations.
  task automatic collect_dump(input int mode, input int limit, input int wb_at,
                              input logic [4:0] wrd, input logic [31:0] wdata, input int rereq_at);
    bit          pend;
    logic [31:0] pd;
    logic        pl;
    int          cyc;
    got_data.delete();
    got_last.delete();
    unstable_cnt = 0;
    timed_out    = 1'b0;
    pend         = 1'b0;
    pd           = '0;
    pl           = 1'b0;
    cyc          = 0;
    while (got_data.size() < limit) begin
      if (cyc >= 600) begin
        timed_out = 1'b1;
        break;
      end
      @(negedge clk);
      cyc++;
      bus.i_dbg_dump_req = (cyc == rereq_at);
      bus.i_dbg_wr_req   = 1'b0;
      bus.i_wb_rd        = (cyc == wb_at) ? wrd : 5'd0;
      bus.i_wb_regwrite  = (cyc == wb_at + 1);
      bus.i_wb_data      = wdata;
      case (mode)
        0:       bus.i_dbg_ready = 1'b1;
        1:       bus.i_dbg_ready = (cyc % 2 == 1);
        default: bus.i_dbg_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (cyc == 1) begin
        busy_first  = bus.o_dbg_busy;
        stall_first = bus.o_stall;
      end
      if (bus.o_dbg_valid) begin
        if (pend && (bus.o_dbg_data !== pd || bus.o_dbg_last !== pl)) unstable_cnt++;
        if (bus.i_dbg_ready) begin
          got_data.push_back(bus.o_dbg_data);
          got_last.push_back(bus.o_dbg_last);
          pend = 1'b0;
        end else begin
          pend = 1'b1;
          pd   = bus.o_dbg_data;
          pl   = bus.o_dbg_last;
        end
      end
    end
    cycles_used = cyc;
    @(negedge clk);
    bus.i_dbg_ready   = 1'b0;
    bus.i_wb_regwrite = 1'b0;
    #1;
    stall_after = bus.o_stall;
    valid_after = bus.o_dbg_valid;
    busy_after  = bus.o_dbg_busy;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    total += 6;
    if (bus.o_stall !== 1'b0) begin bad++; $display("[TB] FAIL reset_stall: got %b want 0", bus.o_stall); end
    if (bus.o_dbg_busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", bus.o_dbg_busy); end
    if (bus.o_dbg_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b want 0", bus.o_dbg_valid); end
    if (bus.o_dbg_last !== 1'b0) begin bad++; $display("[TB] FAIL reset_last: got %b want 0", bus.o_dbg_last); end
    if (bus.o_dbg_data !== 32'd0) begin bad++; $display("[TB] FAIL reset_data: got %h want 0", bus.o_dbg_data); end
    if (bus.o_rb_regwrite !== 1'b0) begin bad++; $display("[TB] FAIL reset_regwrite: got %b want 0", bus.o_rb_regwrite); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_passthrough();
    logic [4:0]  rs, rt, rd;
    logic [31:0] d;
    for (int i = 0; i < 4; i++) begin
      rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom); d = $urandom;
      @(negedge clk);
      bus.i_id_rs = rs; bus.i_id_rt = rt; bus.i_wb_rd = rd; bus.i_wb_data = d;
      #1;
      total += 5;
      if (bus.o_rb_rs !== rs) begin bad++; $display("[TB] FAIL pass_rs: got %h want %h", bus.o_rb_rs, rs); end
      if (bus.o_rb_rt !== rt) begin bad++; $display("[TB] FAIL pass_rt: got %h want %h", bus.o_rb_rt, rt); end
      if (bus.o_rb_rd !== rd) begin bad++; $display("[TB] FAIL pass_rd: got %h want %h", bus.o_rb_rd, rd); end
      if (bus.o_rb_writedata !== d) begin bad++; $display("[TB] FAIL pass_data: got %h want %h", bus.o_rb_writedata, d); end
      if (bus.o_stall !== 1'b0) begin bad++; $display("[TB] FAIL pass_stall: got %b want 0", bus.o_stall); end
    end
    bus.i_id_rs = '0; bus.i_id_rt = '0; bus.i_wb_rd = '0;
  endtask

  task automatic test_dump_basic();
    for (int n = 0; n < 32; n++) pipe_write(5'(n), 32'hA000_0000 + 32'(n));
    @(negedge clk);
    bus.i_dbg_dump_req = 1'b1;
    collect_dump(0, 32, -10, 5'd0, 32'd0, 0);
    total += 7;
    if (timed_out) begin bad++; $display("[TB] FAIL basic_timeout: got timeout want 32 words"); end
    if (got_data.size() != 32) begin bad++; $display("[TB] FAIL basic_count: got %0d want 32", got_data.size()); end
    if (cycles_used != 68) begin bad++; $display("[TB] FAIL basic_cycles: got %0d want 68", cycles_used); end
    if (busy_first !== 1'b1 || stall_first !== 1'b1) begin bad++; $display("[TB] FAIL basic_busy_stall: got %b%b want 11", busy_first, stall_first); end
    if (stall_after !== 1'b0) begin bad++; $display("[TB] FAIL basic_stall_after: got %b want 0", stall_after); end
    if (valid_after !== 1'b0) begin bad++; $display("[TB] FAIL basic_valid_after: got %b want 0", valid_after); end
    if (busy_after !== 1'b0) begin bad++; $display("[TB] FAIL basic_busy_after: got %b want 0", busy_after); end
    for (int i = 0; i < got_data.size(); i++) begin
      total += 2;
      if (got_data[i] !== model[i]) begin bad++; $display("[TB] FAIL basic_word %0d: got %h want %h", i, got_data[i], model[i]); end
      if (got_last[i] !== (i == 31)) begin bad++; $display("[TB] FAIL basic_last %0d: got %b want %b", i, got_last[i], (i == 31)); end
    end
  endtask

  task automatic test_ready_toggle();
    @(negedge clk);
    bus.i_dbg_dump_req = 1'b1;
    collect_dump(1, 32, -10, 5'd0, 32'd0, 20);
    total += 3;
    if (got_data.size() != 32) begin bad++; $display("[TB] FAIL toggle_count: got %0d want 32", got_data.size()); end
    if (unstable_cnt != 0) begin bad++; $display("[TB] FAIL toggle_stable: got %0d changes want 0", unstable_cnt); end
    if (busy_after !== 1'b0) begin bad++; $display("[TB] FAIL toggle_rereq_ignored: got busy %b want 0", busy_after); end
    for (int i = 0; i < got_data.size(); i++) begin
      total += 2;
      if (got_data[i] !== model[i]) begin bad++; $display("[TB] FAIL toggle_word %0d: got %h want %h", i, got_data[i], model[i]); end
      if (got_last[i] !== (i == 31)) begin bad++; $display("[TB] FAIL toggle_last %0d: got %b want %b", i, got_last[i], (i == 31)); end
    end
  endtask

  task automatic test_drain_write();
    @(negedge clk);
    bus.i_dbg_dump_req = 1'b1;
    collect_dump(0, 32, 3, 5'd5, 32'h0000_1234, 0);
    model[5] = 32'h0000_1234;
    total += 2;
    if (got_data.size() != 32) begin bad++; $display("[TB] FAIL drain_count: got %0d want 32", got_data.size()); end
    if (got_data.size() > 5 && got_data[5] !== 32'h0000_1234) begin bad++; $display("[TB] FAIL drain_word5: got %h want 00001234", got_data[5]); end
    for (int i = 0; i < got_data.size(); i++) begin
      total++;
      if (got_data[i] !== model[i]) begin bad++; $display("[TB] FAIL drain_word %0d: got %h want %h", i, got_data[i], model[i]); end
    end
  endtask

  task automatic test_random_ready();
    for (int n = 0; n < 32; n++) pipe_write(5'(n), $urandom);
    @(negedge clk);
    bus.i_dbg_dump_req = 1'b1;
    collect_dump(2, 32, -10, 5'd0, 32'd0, 0);
    total += 3;
    if (got_data.size() != 32) begin bad++; $display("[TB] FAIL rand_count: got %0d want 32", got_data.size()); end
    if (unstable_cnt != 0) begin bad++; $display("[TB] FAIL rand_stable: got %0d changes want 0", unstable_cnt); end
    if (stall_after !== 1'b0) begin bad++; $display("[TB] FAIL rand_stall_after: got %b want 0", stall_after); end
    for (int i = 0; i < got_data.size(); i++) begin
      total += 2;
      if (got_data[i] !== model[i]) begin bad++; $display("[TB] FAIL rand_word %0d: got %h want %h", i, got_data[i], model[i]); end
      if (got_last[i] !== (i == 31)) begin bad++; $display("[TB] FAIL rand_last %0d: got %b want %b", i, got_last[i], (i == 31)); end
    end
  endtask

  task automatic test_reset_mid_dump();
    @(negedge clk);
    bus.i_dbg_dump_req = 1'b1;
    collect_dump(0, 10, -10, 5'd0, 32'd0, 0);
    @(negedge clk);
    bus.i_dbg_ready = 1'b0;
    #1;
    total += 2;
    if (bus.o_dbg_valid !== 1'b1) begin bad++; $display("[TB] FAIL abort_word10_valid: got %b want 1", bus.o_dbg_valid); end
    if (bus.o_dbg_data !== model[10]) begin bad++; $display("[TB] FAIL abort_word10_data: got %h want %h", bus.o_dbg_data, model[10]); end
    #2;
    rst = 1'b1;
    #1;
    total += 4;
    if (bus.o_dbg_valid !== 1'b0) begin bad++; $display("[TB] FAIL abort_valid: got %b want 0", bus.o_dbg_valid); end
    if (bus.o_dbg_busy !== 1'b0) begin bad++; $display("[TB] FAIL abort_busy: got %b want 0", bus.o_dbg_busy); end
    if (bus.o_stall !== 1'b0) begin bad++; $display("[TB] FAIL abort_stall: got %b want 0", bus.o_stall); end
    if (bus.o_dbg_data !== 32'd0) begin bad++; $display("[TB] FAIL abort_data: got %h want 0", bus.o_dbg_data); end
    @(negedge clk);
    rst = 1'b0;
    bus.i_dbg_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      total++;
      if (bus.o_dbg_valid !== 1'b0) begin bad++; $display("[TB] FAIL abort_no_partial: got valid %b want 0", bus.o_dbg_valid); end
    end
    bus.i_dbg_dump_req = 1'b1;
    collect_dump(0, 32, -10, 5'd0, 32'd0, 0);
    total++;
    if (got_data.size() != 32) begin bad++; $display("[TB] FAIL restart_count: got %0d want 32", got_data.size()); end
    for (int i = 0; i < got_data.size(); i++) begin
      total++;
      if (got_data[i] !== model[i]) begin bad++; $display("[TB] FAIL restart_word %0d: got %h want %h", i, got_data[i], model[i]); end
    end
  endtask

  task automatic dbg_write_busy(input logic [4:0] a, input logic [31:0] d, output int busy_cycles);
    @(negedge clk);
    bus.i_dbg_wr_req  = 1'b1;
    bus.i_dbg_wr_addr = a;
    bus.i_dbg_wr_data = d;
    busy_cycles = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      bus.i_dbg_wr_req = 1'b0;
      #1;
      if (bus.o_dbg_busy) busy_cycles++;
    end
  endtask

`ifdef REGBANK_DBG_WRITE_EN
  task automatic test_dbg_write();
    int          bc;
    logic [31:0] r0v;
    dbg_write_busy(5'd7, 32'hDEAD_BEEF, bc);
    model[7] = 32'hDEAD_BEEF;
    total++;
    if (bc != 6) begin bad++; $display("[TB] FAIL wr_busy_cycles: got %0d want 6", bc); end
    r0v = $urandom;
    dbg_write_busy(5'd0, r0v, bc);
    model[0] = r0v;
    @(negedge clk);
    bus.i_dbg_dump_req = 1'b1;
    collect_dump(0, 32, -10, 5'd0, 32'd0, 0);
    total += 2;
    if (got_data.size() != 32) begin bad++; $display("[TB] FAIL wr_dump_count: got %0d want 32", got_data.size()); end
    if (got_data.size() > 7 && got_data[7] !== 32'hDEAD_BEEF) begin bad++; $display("[TB] FAIL wr_word7: got %h want deadbeef", got_data[7]); end
    for (int i = 0; i < got_data.size(); i++) begin
      total++;
      if (got_data[i] !== model[i]) begin bad++; $display("[TB] FAIL wr_dump_word %0d: got %h want %h", i, got_data[i], model[i]); end
    end
    @(negedge clk);
    bus.i_dbg_dump_req = 1'b1;
    bus.i_dbg_wr_req   = 1'b1;
    bus.i_dbg_wr_addr  = 5'd7;
    bus.i_dbg_wr_data  = 32'h5555_5555;
    collect_dump(0, 32, -10, 5'd0, 32'd0, 0);
    total += 3;
    if (got_data.size() != 32) begin bad++; $display("[TB] FAIL both_count: got %0d want 32", got_data.size()); end
    if (cycles_used != 68) begin bad++; $display("[TB] FAIL both_cycles: got %0d want 68", cycles_used); end
    if (busy_after !== 1'b0) begin bad++; $display("[TB] FAIL both_busy_after: got %b want 0", busy_after); end
    for (int i = 0; i < got_data.size(); i++) begin
      total++;
      if (got_data[i] !== model[i]) begin bad++; $display("[TB] FAIL both_word %0d: got %h want %h", i, got_data[i], model[i]); end
    end
  endtask
`else
  task automatic test_dbg_write();
    int bc;
    dbg_write_busy(5'd7, 32'hDEAD_BEEF, bc);
    total++;
    if (bc != 0) begin bad++; $display("[TB] FAIL nowr_busy: got %0d busy cycles want 0", bc); end
    @(negedge clk);
    bus.i_dbg_dump_req = 1'b1;
    collect_dump(0, 32, -10, 5'd0, 32'd0, 0);
    total += 2;
    if (got_data.size() != 32) begin bad++; $display("[TB] FAIL nowr_count: got %0d want 32", got_data.size()); end
    if (got_data.size() > 7 && got_data[7] !== model[7]) begin bad++; $display("[TB] FAIL nowr_word7: got %h want %h", got_data[7], model[7]); end
  endtask
`endif

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got no completion want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.i_wb_regwrite  = 1'b0;
    bus.i_wb_rd        = '0;
    bus.i_wb_data      = '0;
    bus.i_id_rs        = '0;
    bus.i_id_rt        = '0;
    bus.i_dbg_dump_req = 1'b0;
    bus.i_dbg_wr_req   = 1'b0;
    bus.i_dbg_wr_addr  = '0;
    bus.i_dbg_wr_data  = '0;
    bus.i_dbg_ready    = 1'b0;
    $display("[TB] starting");
    test_reset();
    test_passthrough();
    test_dump_basic();
    test_ready_toggle();
    test_drain_write();
    test_random_ready();
    test_reset_mid_dump();
    test_dbg_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
